// File: rtl/shell_pkg.sv
// Shared definitions for the shell response transmitter: ASCII constants,
// response length, FSM state types and the nibble-to-ASCII helper.
// Build option: define SHELL_RESP_PROMPT_EN to append "> " after CR LF.
package shell_pkg;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_PROMPT = 8'h3E;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

`ifdef SHELL_RESP_PROMPT_EN
    localparam int RESP_BYTES = 8;
`else
    localparam int RESP_BYTES = 6;
`endif

    localparam int               IDX_W    = $clog2(RESP_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BYTES - 1);

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_WAIT = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter core. A one-cycle i_Load starts a frame; o_Done is
// registered so that it is high during the last cycle of the stop bit,
// letting the sequencer reload with a single idle cycle between frames.
module uart_tx_core
    import shell_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_Load,
    input  logic [7:0] i_Byte,
    output logic       o_Active,
    output logic       o_Done,
    output logic       o_Serial
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    tx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Frame state machine: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= TX_IDLE;
            bit_cnt  <= CNT_ZERO;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            o_Active <= 1'b0;
            o_Done   <= 1'b0;
            o_Serial <= 1'b1;
        end else begin
            o_Done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    o_Serial <= 1'b1;
                    bit_cnt  <= CNT_ZERO;
                    bit_idx  <= 3'd0;
                    if (i_Load) begin
                        shift    <= i_Byte;
                        o_Serial <= 1'b0;
                        o_Active <= 1'b1;
                        state    <= TX_START;
                    end else begin
                        o_Active <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt  <= CNT_ZERO;
                        o_Serial <= shift[0];
                        state    <= TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= CNT_ZERO;
                        if (bit_idx == 3'd7) begin
                            bit_idx  <= 3'd0;
                            o_Serial <= 1'b1;
                            state    <= TX_STOP;
                        end else begin
                            o_Serial <= shift[1];
                            shift    <= {1'b0, shift[7:1]};
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    // Flag completion one cycle early so it lines up with the final stop cycle
                    if (bit_cnt == CNT_PRE) begin
                        o_Done <= 1'b1;
                    end
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt  <= CNT_ZERO;
                        o_Active <= 1'b0;
                        state    <= TX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= TX_IDLE;
                    o_Serial <= 1'b1;
                    o_Active <= 1'b0;
                    bit_cnt  <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: rtl/shell_resp_tx.sv
// Shell response transmitter: latches a 16-bit value on start and sends it
// as four uppercase hex digits plus CR LF over 8N1 UART.
// Build option: SHELL_RESP_PROMPT_EN appends the "> " prompt (8 bytes total).
module shell_resp_tx
    import shell_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] i_Value,
    input  logic        i_Start,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        UART_TX
);

    seq_state_t       state;
    logic [IDX_W-1:0] byte_idx;
    logic [15:0]      value_q;
    logic             core_load;
    logic [7:0]       core_byte;
    logic             core_active;
    logic             core_done;

    // Select the byte for the current index from the latched value
    always_comb begin
        core_byte = ASCII_SPACE;
        case (byte_idx)
            IDX_W'(0): core_byte = nibble_to_ascii(value_q[15:12]);
            IDX_W'(1): core_byte = nibble_to_ascii(value_q[11:8]);
            IDX_W'(2): core_byte = nibble_to_ascii(value_q[7:4]);
            IDX_W'(3): core_byte = nibble_to_ascii(value_q[3:0]);
            IDX_W'(4): core_byte = ASCII_CR;
            IDX_W'(5): core_byte = ASCII_LF;
`ifdef SHELL_RESP_PROMPT_EN
            IDX_W'(6): core_byte = ASCII_PROMPT;
            IDX_W'(7): core_byte = ASCII_SPACE;
`endif
            default:   core_byte = ASCII_SPACE;
        endcase
    end

    // Response sequencer; o_Busy stays high through the o_Done cycle so a
    // start coinciding with o_Done is ignored
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= SEQ_IDLE;
            byte_idx  <= {IDX_W{1'b0}};
            value_q   <= 16'h0000;
            core_load <= 1'b0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
        end else begin
            core_load <= 1'b0;
            o_Done    <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (i_Start && !o_Busy) begin
                        value_q   <= i_Value;
                        byte_idx  <= {IDX_W{1'b0}};
                        o_Busy    <= 1'b1;
                        core_load <= 1'b1;
                        state     <= SEQ_LOAD;
                    end else begin
                        o_Busy <= 1'b0;
                    end
                end
                SEQ_LOAD: begin
                    state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (core_done) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= SEQ_DONE;
                        end else begin
                            byte_idx  <= byte_idx + IDX_W'(1);
                            core_load <= 1'b1;
                            state     <= SEQ_LOAD;
                        end
                    end else if (!core_active) begin
                        // Core idle without completing: resend the current byte
                        core_load <= 1'b1;
                        state     <= SEQ_LOAD;
                    end else begin
                        state <= SEQ_WAIT;
                    end
                end
                SEQ_DONE: begin
                    o_Done <= 1'b1;
                    state  <= SEQ_IDLE;
                end
                default: begin
                    state  <= SEQ_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .CLK     (CLK),
        .RST     (RST),
        .i_Load  (core_load),
        .i_Byte  (core_byte),
        .o_Active(core_active),
        .o_Done  (core_done),
        .o_Serial(UART_TX)
    );

endmodule

// File: tb/tb_shell_resp_tx.sv
// Self-checking bench for shell_resp_tx with CLKS_PER_BIT = 8. A timing model
// predicts o_Busy/o_Done/UART_TX for every cycle from the accept time, and a
// bench UART receiver checks the decoded bytes against the expected text.
module tb_shell_resp_tx;

    localparam int C = 8;
`ifdef SHELL_RESP_PROMPT_EN
    localparam int NB = 8;
    localparam int T1_LAT = 650;
`else
    localparam int NB = 6;
    localparam int T1_LAT = 488;
`endif
    localparam int FRAME  = 10 * C + 1;
    localparam int K_DONE = NB * FRAME + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] i_Value = 16'h0000;
    logic        i_Start = 1'b0;
    logic        o_Busy;
    logic        o_Done;
    logic        UART_TX;

    shell_resp_tx #(.CLKS_PER_BIT(C)) dut (
        .CLK(CLK), .RST(RST), .i_Value(i_Value), .i_Start(i_Start),
        .o_Busy(o_Busy), .o_Done(o_Done), .UART_TX(UART_TX)
    );

    initial forever #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          active = 1'b0;
    int          acc = 0;
    logic [15:0] mval = 16'h0000;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    int          epoch = 0;
    int          done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] resp_byte(input logic [15:0] v, input int i);
        case (i)
            0: return hexc(v[15:12]);
            1: return hexc(v[11:8]);
            2: return hexc(v[7:4]);
            3: return hexc(v[3:0]);
            4: return 8'h0D;
            5: return 8'h0A;
            6: return 8'h3E;
            default: return 8'h20;
        endcase
    endfunction

    // Line level k edges after the accept edge
    function automatic logic exp_tx(input int k, input logic [15:0] v);
        int j, b, r, bt;
        logic [7:0] by;
        if (k < 1) return 1'b1;
        j = k - 1; b = j / FRAME; r = j % FRAME;
        if (b >= NB || r >= 10 * C) return 1'b1;
        bt = r / C;
        if (bt == 0) return 1'b0;
        if (bt == 9) return 1'b1;
        by = resp_byte(v, b);
        return by[bt-1];
    endfunction

    // Model: accept decision at each rising edge
    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RST) begin
            active = 1'b0;
        end else if (!(active && (cyc - 1 - acc) <= K_DONE) && i_Start) begin
            active = 1'b1;
            acc    = cyc;
            mval   = i_Value;
            for (int i = 0; i < NB; i++) exp_q.push_back(resp_byte(i_Value, i));
        end
    end

    // Model: reset abandons the response
    initial forever begin
        @(posedge RST);
        active = 1'b0;
        exp_q.delete();
        epoch++;
    end

    // Per-cycle comparison of outputs against the model
    initial forever begin
        logic eb, ed, et;
        int k;
        @(negedge CLK);
        if (RST || !active) begin
            eb = 1'b0; ed = 1'b0; et = 1'b1;
        end else begin
            k  = cyc - acc;
            eb = (k <= K_DONE);
            ed = (k == K_DONE);
            et = exp_tx(k, mval);
        end
        check("busy", {31'd0, o_Busy}, {31'd0, eb});
        check("done", {31'd0, o_Done}, {31'd0, ed});
        check("tx",   {31'd0, UART_TX}, {31'd0, et});
        if (o_Done === 1'b1) done_cnt++;
    end

    // Bench UART receiver: mid-bit sampling
    initial forever begin
        logic [7:0] rb;
        logic       stp;
        int         ep;
        @(negedge CLK);
        if (!RST && UART_TX === 1'b0) begin
            ep = epoch;
            repeat (C / 2 - 1) @(negedge CLK);
            if (UART_TX === 1'b0) begin
                for (int b = 0; b < 8; b++) begin
                    repeat (C) @(negedge CLK);
                    rb[b] = UART_TX;
                end
                repeat (C) @(negedge CLK);
                stp = UART_TX;
                if (ep == epoch && !RST) begin
                    check("rx_stop", {31'd0, stp}, 32'd1);
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rx_extra: received %0h, expected no byte", rb);
                    end else if (rb !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL rx_byte: received %0h, expected %0h", rb, exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                    rx_log.push_back(rb);
                end
            end
        end
    end

    task automatic pulse(input logic [15:0] v);
        @(negedge CLK);
        i_Value = v;
        i_Start = 1'b1;
        @(negedge CLK);
        i_Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (o_Done === 1'b1) begin
                lat = cyc - acc + 1;
                break;
            end
        end
        n_chk++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL done_timeout: got no o_Done in 3000 cycles, expected one");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (o_Busy === 1'b0 && !(active && (cyc - acc) <= K_DONE)) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy after 4000 cycles, expected idle");
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int lat, d;
        logic [15:0] rv;
        repeat (3) @(negedge CLK);
        check("reset_tx", {31'd0, UART_TX}, 32'd1);
        check("reset_busy", {31'd0, o_Busy}, 32'd0);
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);

        // 1: 0x1A2F
        rx_log.delete();
        pulse(16'h1A2F);
        wait_done(lat);
        check("t1_latency", lat, T1_LAT);
        repeat (5) @(negedge CLK);
        check("t1_count", rx_log.size(), NB);
        if (rx_log.size() >= 6) begin
            check("t1_b0", {24'd0, rx_log[0]}, 32'h31);
            check("t1_b1", {24'd0, rx_log[1]}, 32'h41);
            check("t1_b2", {24'd0, rx_log[2]}, 32'h32);
            check("t1_b3", {24'd0, rx_log[3]}, 32'h46);
            check("t1_b4", {24'd0, rx_log[4]}, 32'h0D);
            check("t1_b5", {24'd0, rx_log[5]}, 32'h0A);
        end

        // 2: back to back 0x0000 then 0xFFFF
        rx_log.delete();
        pulse(16'h0000);
        wait_done(lat);
        pulse(16'hFFFF);
        wait_done(lat);
        repeat (5) @(negedge CLK);
        check("t2_count", rx_log.size(), 2 * NB);
        if (rx_log.size() >= NB + 4) begin
            check("t2_first", {24'd0, rx_log[0]}, 32'h30);
            check("t2_second", {24'd0, rx_log[NB + 3]}, 32'h46);
        end

        // 3: value change and restart while busy are ignored
        rx_log.delete();
        done_cnt = 0;
        pulse(16'h1234);
        repeat (100) @(negedge CLK);
        pulse(16'hBEEF);
        wait_idle();
        check("t3_done_pulses", done_cnt, 1);
        check("t3_count", rx_log.size(), NB);
        if (rx_log.size() >= 4) check("t3_b3", {24'd0, rx_log[3]}, 32'h34);

        // 4: reset during data bits of byte 2, then 0x00C3
        pulse(16'hABCD);
        repeat (190) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("t4_rst_tx", {31'd0, UART_TX}, 32'd1);
        check("t4_rst_busy", {31'd0, o_Busy}, 32'd0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        repeat (100) @(negedge CLK);
        rx_log.delete();
        pulse(16'h00C3);
        wait_done(lat);
        repeat (5) @(negedge CLK);
        check("t4_count", rx_log.size(), NB);
        if (rx_log.size() >= 4) begin
            check("t4_b2", {24'd0, rx_log[2]}, 32'h43);
            check("t4_b3", {24'd0, rx_log[3]}, 32'h33);
        end

        // 5: start bit latency on 0x5555
        pulse(16'h5555);
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (UART_TX === 1'b0) begin
                lat = cyc - acc + 1;
                break;
            end
        end
        check("t5_start_latency", lat, 2);
        wait_idle();

        // 6: 0x0009 (with prompt when enabled)
        rx_log.delete();
        pulse(16'h0009);
        wait_done(lat);
        check("t6_latency", lat, T1_LAT);
        repeat (5) @(negedge CLK);
        check("t6_count", rx_log.size(), NB);
        if (rx_log.size() >= 4) check("t6_b3", {24'd0, rx_log[3]}, 32'h39);
`ifdef SHELL_RESP_PROMPT_EN
        if (rx_log.size() >= 8) begin
            check("t6_prompt", {24'd0, rx_log[6]}, 32'h3E);
            check("t6_space", {24'd0, rx_log[7]}, 32'h20);
        end
`endif

        // Start held across the o_Done cycle: accepted on the following edge
        pulse(16'h0F0F);
        wait_done(lat);
        d = cyc;
        i_Value = 16'h7777;
        i_Start = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        i_Start = 1'b0;
        check("accept_after_done", acc - d, 2);
        wait_idle();

        // Randomized values with stray starts while busy
        for (int it = 0; it < 6; it++) begin
            rv = 16'($urandom);
            pulse(rv);
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(20, 150)) @(negedge CLK);
                pulse(16'($urandom));
            end
            wait_idle();
        end

        repeat (20) @(negedge CLK);
        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule
